// File: rtl/magnitude_pipe.sv
// magnitude_pipe: three-stage gradient-magnitude unit for the Sobel edge path.
// S1 takes |gx|,|gy|; S2 forms the squared or L1 sum; S3 quantises and saturates
// into the output register. One global advance signal stalls the whole pipe
// when the sink refuses a valid pixel. A saturating counter tallies accepted
// non-zero pixels.
module magnitude_pipe #(
   parameter int G_WIDTH   = 10,
   parameter int PIX_WIDTH = 4,
   parameter int SHIFT     = 4,
   parameter int Q_SQ      = 2,
   parameter int Q_L1      = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic signed [G_WIDTH-1:0]   gx,
   input  logic signed [G_WIDTH-1:0]   gy,
   input  logic        [1:0]           mode,
   input  logic        [G_WIDTH:0]     thresh,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic        [PIX_WIDTH-1:0] pixel,
   output logic                        out_valid,
   input  logic                        out_ready,
   input  logic                        clr_cnt,
   output logic        [CNT_WIDTH-1:0] edge_cnt
);

   localparam int SX_W = G_WIDTH - SHIFT;
   localparam int SQ_W = 2 * SX_W + 1;
   localparam int L1_W = G_WIDTH + 1;
   localparam int S_W  = (SQ_W > L1_W) ? SQ_W : L1_W;

   localparam logic [PIX_WIDTH-1:0] PMAX    = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [1:0]           MODE_L1 = 2'd1;
   localparam logic [1:0]           MODE_TH = 2'd2;

   // Magnitude as unsigned: the most-negative code maps to 2^(G_WIDTH-1) without wrapping.
   function automatic logic [G_WIDTH-1:0] abs_g(input logic signed [G_WIDTH-1:0] v);
      abs_g = v[G_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Clamp a full-precision sum to the pixel range.
   function automatic logic [PIX_WIDTH-1:0] sat_pix(input logic [S_W-1:0] v);
      sat_pix = (v > S_W'(PMAX)) ? PMAX : v[PIX_WIDTH-1:0];
   endfunction

   logic                 adv;
   logic                 vld_p1_q, vld_p2_q;
   logic [G_WIDTH-1:0]   ax_p1_q, ay_p1_q;
   logic [1:0]           mode_p1_q, mode_p2_q;
   logic [G_WIDTH:0]     thresh_p1_q, thresh_p2_q;
   logic [S_W-1:0]       s_p2_q;
   logic [PIX_WIDTH-1:0] pixel_q;
   logic                 out_valid_q;
   logic [CNT_WIDTH-1:0] edge_cnt_q;

   logic [G_WIDTH-1:0]   ax_d, ay_d;
   logic [SQ_W-1:0]      sx_d, sy_d, sq_d;
   logic [L1_W-1:0]      l1_d;
   logic [S_W-1:0]       s_d;
   logic [PIX_WIDTH-1:0] pix_d;
   logic                 hs_nz;

   assign adv       = !(out_valid_q && !out_ready);
   assign in_ready  = adv;
   assign pixel     = pixel_q;
   assign out_valid = out_valid_q;
   assign edge_cnt  = edge_cnt_q;

   // Stage arithmetic: abs at the input, sum between S1 and S2, quantise between S2 and S3.
   always_comb begin
      ax_d  = abs_g(gx);
      ay_d  = abs_g(gy);
      sx_d  = SQ_W'(ax_p1_q >> SHIFT);
      sy_d  = SQ_W'(ay_p1_q >> SHIFT);
      sq_d  = sx_d * sx_d + sy_d * sy_d;
      l1_d  = L1_W'(ax_p1_q) + L1_W'(ay_p1_q);
      s_d   = S_W'(sq_d);
      if (mode_p1_q == MODE_L1 || mode_p1_q == MODE_TH)
         s_d = S_W'(l1_d);
      pix_d = sat_pix(s_p2_q >> Q_SQ);
      if (mode_p2_q == MODE_L1)
         pix_d = sat_pix(s_p2_q >> Q_L1);
      else if (mode_p2_q == MODE_TH)
         pix_d = (s_p2_q >= S_W'(thresh_p2_q)) ? PMAX : '0;
   end

   // Valid chain and output register; everything holds while the sink stalls.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         out_valid_q <= 1'b0;
         pixel_q     <= '0;
      end else if (adv) begin
         // stage boundary: input -> S1 -> S2 -> output
         vld_p1_q    <= in_valid;
         vld_p2_q    <= vld_p1_q;
         out_valid_q <= vld_p2_q;
         if (vld_p2_q)
            pixel_q <= pix_d;
      end
   end

   // Datapath registers carry mode/thresh alongside the data; no reset needed.
   always_ff @(posedge clk) begin
      if (adv) begin
         // stage boundary: input -> S1
         ax_p1_q     <= ax_d;
         ay_p1_q     <= ay_d;
         mode_p1_q   <= mode;
         thresh_p1_q <= thresh;
         // stage boundary: S1 -> S2
         s_p2_q      <= s_d;
         mode_p2_q   <= mode_p1_q;
         thresh_p2_q <= thresh_p1_q;
      end
   end

   assign hs_nz = out_valid_q && out_ready && (pixel_q != '0);

   // Saturating edge counter; a coincident clear and increment leaves exactly one.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         edge_cnt_q <= '0;
      else if (clr_cnt)
         edge_cnt_q <= hs_nz ? CNT_WIDTH'(1) : '0;
      else if (hs_nz && edge_cnt_q != CNT_MAX)
         edge_cnt_q <= edge_cnt_q + 1'b1;
   end

endmodule
